// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - program_loader states, protocol bytes and byte-lane helper (LOADER_CHECKSUM_EN adds RECV_SUM)
package loader_pkg;

  typedef enum logic [2:0] {
    SEND_SYNC = 3'd0,
    RECV_SIZE = 3'd1,
    RECV_PROG = 3'd2,
    SEND_ACK  = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
`ifdef LOADER_CHECKSUM_EN
    , RECV_SUM = 3'd6
`endif
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h99;
  localparam logic [7:0] ACK_BYTE  = 8'haa;

  // Drop one byte into a 32-bit word at the given little-endian lane.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = data;
      2'd1:    r[15:8]  = data;
      2'd2:    r[23:16] = data;
      default: r[31:24] = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_to_word.sv
// rtl/byte_to_word.sv - little-endian byte packer producing one instruction-memory write per word
module byte_to_word
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           wdata
);

  logic [31:0]           asm_q;
  logic [1:0]            lane_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [31:0]           merged;

  // Current assembly word with the incoming byte placed in its lane.
  always_comb begin
    merged = place_byte(asm_q, lane_q, byte_data);
  end

  // Accumulate bytes; flush on the 4th byte or on the final byte, zero
  // upper lanes being guaranteed because asm_q is cleared after each flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      asm_q       <= '0;
      lane_q      <= '0;
      next_addr_q <= '0;
      we          <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
    end else begin
      we <= 1'b0;
      if (byte_valid) begin
        if (lane_q == 2'd3 || byte_last) begin
          we          <= 1'b1;
          addr        <= next_addr_q;
          wdata       <= merged;
          next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
          asm_q       <= '0;
          lane_q      <= '0;
        end else begin
          asm_q  <= merged;
          lane_q <= lane_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART boot loader FSM: sync, size, program, ack (LOADER_CHECKSUM_EN adds checksum byte)
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rdata,
  input  logic                  ferr,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            sdata,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  boot_done,
  output logic                  load_err
);

  // Largest program that fits the instruction memory, in bytes.
  localparam logic [32:0] MAX_BYTES = 33'd4 << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t POST_PROG = RECV_SUM;
`else
  localparam state_t POST_PROG = SEND_ACK;
`endif

  state_t      state_q, state_d;
  logic [31:0] size_q, size_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tx_start_d;
  logic [7:0]  sdata_d;
  logic        byte_valid;
  logic        byte_last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  // Next-state, counter updates and transmit requests.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    sdata_d    = sdata;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      SEND_SYNC: begin
        // tx_start is registered, so also wait out our own pulse cycle.
        if (!tx_busy && !tx_start) begin
          tx_start_d = 1'b1;
          sdata_d    = SYNC_BYTE;
          state_d    = RECV_SIZE;
        end
      end
      RECV_SIZE: begin
        if (rx_ready) begin
          if (ferr) begin
            state_d = ERROR;
          end else begin
            size_d = place_byte(size_q, idx_q, rdata);
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if ({1'b0, size_d} > MAX_BYTES) begin
                state_d = ERROR;
              end else if (size_d == 32'd0) begin
                state_d = POST_PROG;
              end else begin
                state_d = RECV_PROG;
              end
            end
          end
        end
      end
      RECV_PROG: begin
        if (rx_ready) begin
          if (ferr) begin
            state_d = ERROR;
          end else begin
            byte_valid = 1'b1;
            cnt_d      = cnt_q + 32'd1;
            // 33-bit compare so the count can never alias past N.
            byte_last  = (({1'b0, cnt_q} + 33'd1) == {1'b0, size_q});
`ifdef LOADER_CHECKSUM_EN
            sum_d      = sum_q ^ rdata;
`endif
            if (byte_last) begin
              state_d = POST_PROG;
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      RECV_SUM: begin
        if (rx_ready) begin
          if (ferr || rdata != sum_q) begin
            state_d = ERROR;
          end else begin
            state_d = SEND_ACK;
          end
        end
      end
`endif
      SEND_ACK: begin
        if (!tx_busy && !tx_start) begin
          tx_start_d = 1'b1;
          sdata_d    = ACK_BYTE;
          state_d    = DONE;
        end
      end
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = SEND_SYNC;
    endcase
  end

  // State, counters and registered outputs; reset forces a clean restart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= SEND_SYNC;
      size_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_start  <= 1'b0;
      sdata     <= '0;
      boot_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_start  <= tx_start_d;
      sdata     <= sdata_d;
      boot_done <= (state_d == DONE);
      load_err  <= (state_d == ERROR);
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  byte_to_word #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_byte_to_word (
    .clock     (clock),
    .reset     (reset),
    .byte_valid(byte_valid),
    .byte_data (rdata),
    .byte_last (byte_last),
    .we        (imem_we),
    .addr      (imem_addr),
    .wdata     (imem_wdata)
  );

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, instruction-memory word-address width.
REQ-002 clock  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_ready  input  1  one-cycle strobe from the UART receiver: rdata valid this cycle.
REQ-005 rdata  input  8  received byte.
REQ-006 ferr  input  1  UART framing error, sampled with rx_ready.
REQ-007 tx_busy  input  1  UART transmitter busy.
REQ-008 tx_start  output  1  one-cycle request to transmit sdata.
REQ-009 sdata  output  8  byte to transmit, stable from the tx_start cycle until tx_busy falls.
REQ-010 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 imem_addr  output  ADDR_WIDTH  word address of the current write.
REQ-012 imem_wdata  output  32  word to write.
REQ-013 boot_done  output  1  program loaded and acknowledged; CPU may leave reset.
REQ-014 load_err  output  1  sticky error flag.

Function
REQ-015 The FSM SHALL have states SEND_SYNC, RECV_SIZE, RECV_PROG, SEND_ACK, DONE and ERROR (plus RECV_SUM under REQ-030).
REQ-016 SEND_SYNC SHALL assert tx_start with sdata=8'h99 on the first cycle tx_busy=0, then enter RECV_SIZE.
REQ-017 RECV_SIZE SHALL accept 4 bytes, least-significant first, as a 32-bit byte count N.
REQ-018 If N > 4*2^ADDR_WIDTH, the FSM SHALL enter ERROR after the 4th size byte.
REQ-019 If N = 0, the FSM SHALL go directly to SEND_ACK, with no imem writes.
REQ-020 RECV_PROG SHALL pack bytes little-endian (first byte into bits [7:0]) and assert imem_we in the cycle after each 4th byte; imem_addr SHALL start at 0 and increment by 1 per write.
REQ-021 If N is not a multiple of 4, the final partial word SHALL be zero-padded in its upper bytes and written in the cycle after byte N.
REQ-022 After byte N (and its write), the FSM SHALL enter SEND_ACK.
REQ-023 SEND_ACK SHALL transmit 8'haa under the same rule as REQ-016, then enter DONE.
REQ-024 DONE SHALL hold boot_done=1 and ignore all rx_ready until reset.
REQ-025 rx_ready with ferr=1 in any receiving state SHALL enter ERROR without using the byte; load_err=1 and boot_done=0 until reset.
REQ-026 rx_ready in SEND_SYNC or SEND_ACK SHALL be ignored (byte dropped).
REQ-027 The byte counter SHALL be 32 bits; the comparison with N SHALL be exact, with no wrap-around.
REQ-028 tx_start SHALL never be asserted while tx_busy=1, and never on two consecutive cycles.

Reset
REQ-029 Asserting reset, including mid-transfer, SHALL force SEND_SYNC with all outputs 0, counters 0 and the assembly register 0; a partial word SHALL NOT be written.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, RECV_PROG SHALL go to RECV_SUM, which receives one byte compared against the XOR of all N program bytes (8'h00 when N=0): equal goes to SEND_ACK, mismatch goes to ERROR. Without the macro, RECV_SUM and the XOR logic SHALL be absent and REQ-022 applies.

Structure
REQ-031 Package loader_pkg SHALL hold the state enum and the constants SYNC_BYTE=8'h99 and ACK_BYTE=8'haa.
REQ-032 Sub-module byte_to_word SHALL do the little-endian packing, padding and write strobe; the top handles the FSM, counters and UART handshake.

Verification
REQ-033 Reset released, tx_busy=0 -> exactly one tx_start with sdata=8'h99; no further tx_start until size is complete.
REQ-034 Size bytes 08 00 00 00, then 11 22 33 44 55 66 77 88 -> writes addr0=32'h44332211 and addr1=32'h88776655, then tx_start with 8'haa, then boot_done=1.
REQ-035 N=6 with bytes 01..06 -> addr0=32'h04030201, addr1=32'h00000605, then ACK.
REQ-036 Size 00 00 00 00 -> no imem_we, ACK immediately; and ferr on the 3rd program byte -> load_err=1, no ACK.
REQ-037 Reset asserted after 2 of 4 program bytes -> no imem_we; 8'h99 is resent after release and a full reload succeeds.
REQ-038 With LOADER_CHECKSUM_EN: N=4 with bytes 01 02 04 08 and checksum 0F -> ACK; checksum 0E -> load_err=1.
